// File: rtl/pwl_coef_loader_pkg.sv
// pwl_coef_loader_pkg: shared sizes, FSM state encoding and error codes for the PWL coefficient loader (rev 1.0).
`default_nettype none

package pwl_coef_loader_pkg;

  localparam int BITSIZE    = 16;
  localparam int N_BRK      = 16;
  localparam int N_SEG      = N_BRK + 1;
  localparam int LOAD_WORDS = N_BRK + 2 * N_SEG;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_X = 3'd1,
    LOAD_M = 3'd2,
    LOAD_C = 3'd3,
    COMMIT = 3'd4,
    DRAIN  = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_NONMONO = 2'd1;
  localparam logic [1:0] ERR_SHORT   = 2'd2;
  localparam logic [1:0] ERR_LONG    = 2'd3;

endpackage

`default_nettype wire

// File: rtl/pwl_coef_loader_sm16_greater.sv
// sm16_greater: combinational sign-magnitude a > b, with -0 and +0 treated as equal (rev 1.0).
`default_nettype none

module sm16_greater
  import pwl_coef_loader_pkg::*;
#(
  parameter int W = BITSIZE
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         gt
);

  logic [W-2:0] a_mag, b_mag;
  logic         a_neg, b_neg;

  assign a_mag = a[W-2:0];
  assign b_mag = b[W-2:0];
  // A zero magnitude is never negative, so both zeros land in the same class.
  assign a_neg = a[W-1] && (a_mag != '0);
  assign b_neg = b[W-1] && (b_mag != '0);

  always_comb begin
    if (a_neg != b_neg) gt = b_neg;
    else if (!a_neg)    gt = (a_mag > b_mag);
    else                gt = (a_mag < b_mag);
  end

endmodule

`default_nettype wire

// File: rtl/pwl_coef_loader.sv
// pwl_coef_loader: streams x/m/c words into a shadow bank, validates, and commits atomically (rev 1.0).
// Optional active-bank readback port enabled by PWL_LOADER_READBACK_EN.
`default_nettype none

module pwl_coef_loader
  import pwl_coef_loader_pkg::*;
#(
  parameter int BITSIZE = pwl_coef_loader_pkg::BITSIZE,
  parameter int N_BRK   = pwl_coef_loader_pkg::N_BRK,
  parameter int N_SEG   = pwl_coef_loader_pkg::N_SEG
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [BITSIZE-1:0]       s_data,
  input  logic                     s_last,
  output logic [N_BRK*BITSIZE-1:0] x_bus,
  output logic [N_SEG*BITSIZE-1:0] m_bus,
  output logic [N_SEG*BITSIZE-1:0] c_bus,
  output logic                     tbl_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [1:0]               err_code
`ifdef PWL_LOADER_READBACK_EN
  ,
  input  logic [5:0]               rd_addr,
  output logic [BITSIZE-1:0]       rd_data
`endif
);

  localparam logic [5:0] X_END    = 6'(N_BRK - 1);
  localparam logic [5:0] M_END    = 6'(N_BRK + N_SEG - 1);
  localparam logic [5:0] LAST_IDX = 6'(N_BRK + 2 * N_SEG - 1);

  state_t             state, state_nx;
  logic [5:0]         cnt;
  logic [BITSIZE-1:0] x_sh [N_BRK];
  logic [BITSIZE-1:0] m_sh [N_SEG];
  logic [BITSIZE-1:0] c_sh [N_SEG];
  logic [BITSIZE-1:0] prev_x;
  logic               bad;
  logic               xfer, wr, gt, load_nx, short_last;

  assign s_ready    = (state != COMMIT);
  assign busy       = (state != IDLE);
  assign xfer       = s_valid && s_ready;
  assign wr         = xfer && (state inside {IDLE, LOAD_X, LOAD_M, LOAD_C});
  assign short_last = s_last && (cnt != LAST_IDX);
  assign load_nx    = (state_nx inside {LOAD_X, LOAD_M, LOAD_C});

  sm16_greater #(.W(BITSIZE)) u_gt (
    .a  (s_data),
    .b  (prev_x),
    .gt (gt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (xfer) state_nx = short_last ? IDLE : LOAD_X;
      LOAD_X:  if (xfer) state_nx = short_last ? IDLE : ((cnt == X_END) ? LOAD_M : LOAD_X);
      LOAD_M:  if (xfer) state_nx = short_last ? IDLE : ((cnt == M_END) ? LOAD_C : LOAD_M);
      LOAD_C: begin
        if (xfer) begin
          if (cnt == LAST_IDX) state_nx = s_last ? COMMIT : DRAIN;
          else if (s_last)     state_nx = IDLE;
        end
      end
      COMMIT:  state_nx = IDLE;
      DRAIN:   if (xfer && s_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      bad       <= 1'b0;
      prev_x    <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      tbl_valid <= 1'b0;
      x_bus     <= '0;
      m_bus     <= '0;
      c_bus     <= '0;
      for (int i = 0; i < N_BRK; i++) x_sh[i] <= '0;
      for (int k = 0; k < N_SEG; k++) begin
        m_sh[k] <= '0;
        c_sh[k] <= '0;
      end
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (wr) begin
        cnt <= load_nx ? cnt + 6'd1 : 6'd0;
        for (int i = 0; i < N_BRK; i++)
          if (cnt == 6'(i)) x_sh[i] <= s_data;
        for (int k = 0; k < N_SEG; k++) begin
          if (cnt == 6'(N_BRK + k))         m_sh[k] <= s_data;
          if (cnt == 6'(N_BRK + N_SEG + k)) c_sh[k] <= s_data;
        end
        if (cnt <= X_END) prev_x <= s_data;
        // The first word of a load starts a fresh ordering check.
        if (state == IDLE)               bad <= 1'b0;
        else if (cnt <= X_END && !gt)    bad <= 1'b1;
        if (short_last) begin
          err      <= 1'b1;
          err_code <= ERR_SHORT;
        end else if (!s_last && cnt == LAST_IDX) begin
          err      <= 1'b1;
          err_code <= ERR_LONG;
        end
      end
      if (state == COMMIT) begin
        if (!bad) begin
          for (int i = 0; i < N_BRK; i++) x_bus[i*BITSIZE +: BITSIZE] <= x_sh[i];
          for (int k = 0; k < N_SEG; k++) begin
            m_bus[k*BITSIZE +: BITSIZE] <= m_sh[k];
            c_bus[k*BITSIZE +: BITSIZE] <= c_sh[k];
          end
          tbl_valid <= 1'b1;
          done      <= 1'b1;
        end else begin
          err      <= 1'b1;
          err_code <= ERR_NONMONO;
        end
      end
    end
  end

`ifdef PWL_LOADER_READBACK_EN
  logic [BITSIZE-1:0] rd_mux;

  // Load-order addressing; anything past the last word reads as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_BRK; i++)
      if (rd_addr == 6'(i)) rd_mux = x_bus[i*BITSIZE +: BITSIZE];
    for (int k = 0; k < N_SEG; k++) begin
      if (rd_addr == 6'(N_BRK + k))         rd_mux = m_bus[k*BITSIZE +: BITSIZE];
      if (rd_addr == 6'(N_BRK + N_SEG + k)) rd_mux = c_bus[k*BITSIZE +: BITSIZE];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data <= '0;
    else       rd_data <= rd_mux;
  end
`else
  // No readback path in this build.
`endif

endmodule

`default_nettype wire

// File: tb/tb_pwl_coef_loader.sv
// tb_pwl_coef_loader: directed self-checking bench for the PWL coefficient loader.
`default_nettype none

module tb_pwl_coef_loader;

  localparam int W  = 16;
  localparam int NB = 16;
  localparam int NS = 17;

  logic            clk = 1'b0;
  logic            reset;
  logic            s_valid, s_ready, s_last;
  logic [W-1:0]    s_data;
  logic [NB*W-1:0] x_bus;
  logic [NS*W-1:0] m_bus, c_bus;
  logic            tbl_valid, busy, done, err;
  logic [1:0]      err_code;
`ifdef PWL_LOADER_READBACK_EN
  logic [5:0]      rd_addr;
  logic [W-1:0]    rd_data;
`endif

  int tests = 0;
  int fails = 0;

  logic [W-1:0]    words [64];
  logic [NB*W-1:0] exp_x, nom_x;
  logic [NS*W-1:0] exp_m, exp_c, nom_m, nom_c;

  pwl_coef_loader dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .x_bus     (x_bus),
    .m_bus     (m_bus),
    .c_bus     (c_bus),
    .tbl_valid (tbl_valid),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_code  (err_code)
`ifdef PWL_LOADER_READBACK_EN
    ,
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Nominal pattern: x ascends from -0x700 through 0 to +0x800; m/c offset by a base.
  task automatic fill_words(input logic [W-1:0] mbase, input logic [W-1:0] cbase);
    for (int i = 0; i < 7; i++) words[i] = 16'h8700 - 16'(i) * 16'h0100;
    for (int i = 7; i < NB; i++) words[i] = 16'(i - 7) * 16'h0100;
    for (int k = 0; k < NS; k++) begin
      words[NB + k]      = mbase + 16'(k);
      words[NB + NS + k] = cbase + 16'(k);
    end
    for (int i = NB + 2 * NS; i < 64; i++) words[i] = 16'hABC0 + 16'(i);
  endtask

  task automatic pack_expected();
    for (int i = 0; i < NB; i++) exp_x[i*W +: W] = words[i];
    for (int k = 0; k < NS; k++) begin
      exp_m[k*W +: W] = words[NB + k];
      exp_c[k*W +: W] = words[NB + NS + k];
    end
  endtask

  // Sends words[first..first+n-1], asserting s_last on index last_idx; valid stays high at exit.
  task automatic send_seq(input int first, input int n, input int last_idx, input bit gaps);
    int guard;
    for (int i = first; i < first + n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        tick();
      end
      guard = 0;
      while (!s_ready && guard < 8) begin
        s_valid = 1'b0;
        tick();
        guard++;
      end
      if (!s_ready) begin
        tests++; fails++;
        $display("FAIL ready_timeout: s_ready=%0b required 1", s_ready);
      end
      s_valid = 1'b1;
      s_data  = words[i];
      s_last  = (i == last_idx);
      tick();
    end
  endtask

  task automatic idle_inputs();
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    tests++;
    if ({s_ready, busy, tbl_valid, done, err, err_code} !== 7'b1000000) begin
      fails++;
      $display("FAIL reset_ctrl: got rdy/busy/tv/done/err/code=%b required 1000000",
               {s_ready, busy, tbl_valid, done, err, err_code});
    end
    tests++;
    if (x_bus !== '0 || m_bus !== '0 || c_bus !== '0) begin
      fails++; $display("FAIL reset_banks: x_bus[15:0]=%h m_bus[15:0]=%h required 0", x_bus[15:0], m_bus[15:0]);
    end
  endtask

  task automatic test_nonmono();
    fill_words(16'h0040, 16'h1000);
    words[5] = words[4];
    send_seq(0, 50, 49, 1'b0);
    idle_inputs();
    tick();
    tests++;
    if (err !== 1'b1 || done !== 1'b0 || err_code !== 2'd1) begin
      fails++; $display("FAIL nonmono_err: err=%b done=%b code=%0d required 1 0 1", err, done, err_code);
    end
    tests++;
    if (tbl_valid !== 1'b0 || x_bus !== '0) begin
      fails++; $display("FAIL nonmono_bank: tbl_valid=%b x_bus[15:0]=%h required 0 0000", tbl_valid, x_bus[15:0]);
    end
    // -0 followed by +0 must also be rejected.
    fill_words(16'h0040, 16'h1000);
    words[7] = 16'h8000;
    words[8] = 16'h0000;
    tick();
    send_seq(0, 50, 49, 1'b0);
    idle_inputs();
    tick();
    tests++;
    if (err !== 1'b1 || tbl_valid !== 1'b0) begin
      fails++; $display("FAIL zero_pair: err=%b tbl_valid=%b required 1 0", err, tbl_valid);
    end
    tick();
  endtask

  task automatic test_nominal();
    fill_words(16'h0040, 16'h1000);
    pack_expected();
    nom_x = exp_x; nom_m = exp_m; nom_c = exp_c;
    send_seq(0, 1, 99, 1'b0);
    tests++;
    if (busy !== 1'b1 || tbl_valid !== 1'b0) begin
      fails++; $display("FAIL nominal_busy: busy=%b tbl_valid=%b required 1 0", busy, tbl_valid);
    end
    send_seq(1, 49, 49, 1'b0);
    idle_inputs();
    tests++;
    if (s_ready !== 1'b0 || done !== 1'b0 || tbl_valid !== 1'b0 || x_bus !== '0) begin
      fails++; $display("FAIL commit_cycle: s_ready=%b done=%b tbl_valid=%b required 0 0 0", s_ready, done, tbl_valid);
    end
    tick();
    tests++;
    if (done !== 1'b1 || err !== 1'b0 || tbl_valid !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL nominal_done: done=%b err=%b tbl_valid=%b busy=%b required 1 0 1 0", done, err, tbl_valid, busy);
    end
    tests++;
    if (x_bus[15:0] !== 16'h8700 || x_bus !== exp_x) begin
      fails++; $display("FAIL nominal_x: x_bus[15:0]=%h required 8700", x_bus[15:0]);
    end
    tests++;
    if (m_bus !== exp_m || c_bus !== exp_c) begin
      fails++; $display("FAIL nominal_mc: m_bus[15:0]=%h c_bus[15:0]=%h required 0040 1000", m_bus[15:0], c_bus[15:0]);
    end
    tests++;
    if (err_code !== 2'd1) begin
      fails++; $display("FAIL code_held: err_code=%0d required 1", err_code);
    end
    tick();
    tests++;
    if (done !== 1'b0) begin
      fails++; $display("FAIL done_pulse: done=%b required 0", done);
    end
  endtask

  task automatic test_readback();
`ifdef PWL_LOADER_READBACK_EN
    rd_addr = 6'd16;
    tick();
    tests++;
    if (rd_data !== 16'h0040) begin
      fails++; $display("FAIL rd_16: rd_data=%h required 0040", rd_data);
    end
    rd_addr = 6'd55;
    tick();
    tests++;
    if (rd_data !== 16'h0000) begin
      fails++; $display("FAIL rd_55: rd_data=%h required 0000", rd_data);
    end
    rd_addr = 6'd49;
    tick();
    tests++;
    if (rd_data !== 16'h1010) begin
      fails++; $display("FAIL rd_49: rd_data=%h required 1010", rd_data);
    end
`endif
  endtask

  task automatic test_short();
    fill_words(16'h0200, 16'h3000);
    send_seq(0, 21, 20, 1'b0);
    idle_inputs();
    tests++;
    if (err !== 1'b1 || err_code !== 2'd2 || busy !== 1'b0) begin
      fails++; $display("FAIL short_err: err=%b code=%0d busy=%b required 1 2 0", err, err_code, busy);
    end
    tests++;
    if (x_bus !== nom_x || m_bus !== nom_m || c_bus !== nom_c || tbl_valid !== 1'b1) begin
      fails++; $display("FAIL short_keep: m_bus[15:0]=%h tbl_valid=%b required 0040 1", m_bus[15:0], tbl_valid);
    end
    tick();
    tests++;
    if (err !== 1'b0) begin
      fails++; $display("FAIL short_pulse: err=%b required 0", err);
    end
  endtask

  task automatic test_long();
    fill_words(16'h0300, 16'h4000);
    pack_expected();
    send_seq(0, 50, 99, 1'b0);
    tests++;
    if (err !== 1'b1 || err_code !== 2'd3 || busy !== 1'b1 || s_ready !== 1'b1) begin
      fails++; $display("FAIL long_err: err=%b code=%0d busy=%b rdy=%b required 1 3 1 1", err, err_code, busy, s_ready);
    end
    send_seq(50, 3, 52, 1'b0);
    idle_inputs();
    tests++;
    if (busy !== 1'b0 || err !== 1'b0 || m_bus !== nom_m) begin
      fails++; $display("FAIL drain_end: busy=%b err=%b m_bus[15:0]=%h required 0 0 0040", busy, err, m_bus[15:0]);
    end
    tick();
    send_seq(0, 50, 49, 1'b0);
    idle_inputs();
    tick();
    tests++;
    if (done !== 1'b1 || m_bus !== exp_m || c_bus !== exp_c || err_code !== 2'd3) begin
      fails++; $display("FAIL after_drain: done=%b m_bus[15:0]=%h code=%0d required 1 0300 3", done, m_bus[15:0], err_code);
    end
  endtask

  task automatic test_reset_midload();
    fill_words(16'h0500, 16'h6000);
    pack_expected();
    send_seq(0, 30, 99, 1'b1);
    reset = 1'b1;
    #1;
    tests++;
    if ({s_ready, busy, tbl_valid, done, err, err_code} !== 7'b1000000 || x_bus !== '0 || c_bus !== '0) begin
      fails++; $display("FAIL midload_reset: rdy/busy/tv/done/err/code=%b required 1000000",
                        {s_ready, busy, tbl_valid, done, err, err_code});
    end
    idle_inputs();
    tick();
    reset = 1'b0;
    tick();
    send_seq(0, 50, 49, 1'b1);
    idle_inputs();
    tick();
    tests++;
    if (done !== 1'b1 || tbl_valid !== 1'b1 || x_bus !== exp_x || m_bus !== exp_m || c_bus !== exp_c) begin
      fails++; $display("FAIL gaps_commit: done=%b tv=%b m_bus[15:0]=%h required 1 1 0500", done, tbl_valid, m_bus[15:0]);
    end
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
`ifdef PWL_LOADER_READBACK_EN
    rd_addr = '0;
`endif
    test_reset();
    test_nonmono();
    test_nominal();
    test_readback();
    test_short();
    test_long();
    test_reset_midload();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
